// File: rtl/axi_stream_pkg.sv
// Shared definitions for the frame writer: FSM encoding and default widths.
package axi_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned TUSER_WIDTH_DEF = 8;
    localparam int unsigned LEN_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/axi_frame_writer_if.sv
// AXI-Stream bundle carrying framed samples (tuser = frame sequence number).
interface axi_frame_writer_if
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned TUSER_WIDTH = TUSER_WIDTH_DEF
);

    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axi_skid_2.sv
// Two-entry output buffer: head is presented downstream, tail waits behind it.
// tail_last_set marks the tail as end of frame and never touches the head.
module axi_skid_2
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned TUSER_WIDTH = TUSER_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic [TUSER_WIDTH-1:0] push_user,
    input  logic                   push_last,
    input  logic                   pop,
    input  logic                   tail_last_set,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TUSER_WIDTH-1:0] out_user,
    output logic                   out_last,
    output logic                   full_c
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
    } beat_t;

    beat_t head_q, head_d, tail_q, tail_d, push_beat;
    logic  head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

    assign push_beat = beat_t'{data: push_data, user: push_user, last: push_last};

    // Pop first, then append, so a simultaneous push and pop never overflows.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;

        if (tail_last_set && tail_vld_q && !pop) begin
            tail_d.last = 1'b1;
        end

        if (pop && head_vld_q) begin
            head_d     = tail_d;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end

        if (push) begin
            if (!head_vld_d) begin
                head_d     = push_beat;
                head_vld_d = 1'b1;
            end else if (!tail_vld_d) begin
                tail_d     = push_beat;
                tail_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    assign out_valid = head_vld_q;
    assign out_data  = head_q.data;
    assign out_user  = head_q.user;
    assign out_last  = head_q.last;
    assign full_c    = tail_vld_q;

endmodule

// File: rtl/axi_frame_writer.sv
// Packs a backpressure-free sample stream into AXI-Stream frames, dropping or
// truncating frames the downstream cannot take. Stats counters: AXI_FRAME_WRITER_STATS_EN.
module axi_frame_writer
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned TUSER_WIDTH = TUSER_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  almost_full,
    axi_frame_writer_if.master    m_axis,
    output logic [LEN_WIDTH-1:0]  drop_cnt,
    output logic [LEN_WIDTH-1:0]  trunc_cnt
);

    fsm_state_e             state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   eff_len_c, beat_len_c, beat_num_c;
    logic [TUSER_WIDTH-1:0] seq_q, seq_d, cur_seq_q, cur_seq_d, beat_user_c;
    logic                   trunc_q, trunc_d;
    logic                   idle_c, pass_mode_c, is_last_c, pass_beat_c;
    logic                   overflow_c, push_c, pop_c, full_c;
    logic                   drop_inc_c, trunc_inc_c;
    logic                   head_valid, head_last;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [TUSER_WIDTH-1:0] head_user;

    assign eff_len_c = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;

    // Beat decode: in IDLE the incoming sample is beat 1 of a new frame.
    always_comb begin
        idle_c      = (state_q == ST_IDLE);
        pass_mode_c = idle_c ? !almost_full : (state_q == ST_PASS);
        beat_len_c  = idle_c ? eff_len_c : len_q;
        beat_num_c  = idle_c ? LEN_WIDTH'(1) : cnt_q + LEN_WIDTH'(1);
        beat_user_c = idle_c ? seq_q : cur_seq_q;
        is_last_c   = (beat_num_c == beat_len_c);
        pass_beat_c = din_valid && pass_mode_c;
        pop_c       = head_valid && m_axis.tready;
        overflow_c  = pass_beat_c && full_c && !pop_c;
        push_c      = pass_beat_c && !overflow_c;
        trunc_inc_c = overflow_c;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        cur_seq_d  = cur_seq_q;
        trunc_d    = trunc_q;
        drop_inc_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    len_d     = eff_len_c;
                    cnt_d     = LEN_WIDTH'(1);
                    cur_seq_d = seq_q;
                    seq_d     = seq_q + TUSER_WIDTH'(1);
                    trunc_d   = overflow_c;
                    if (is_last_c) begin
                        drop_inc_c = !pass_mode_c;
                    end else if (push_c) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                if (din_valid) begin
                    cnt_d = beat_num_c;
                    if (is_last_c) begin
                        state_d = ST_IDLE;
                    end else if (overflow_c) begin
                        state_d = ST_DROP;
                        trunc_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (din_valid) begin
                    cnt_d = beat_num_c;
                    if (is_last_c) begin
                        state_d    = ST_IDLE;
                        // a truncated frame is already counted in trunc_cnt
                        drop_inc_c = !trunc_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            cur_seq_q <= '0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            cur_seq_q <= cur_seq_d;
            trunc_q   <= trunc_d;
        end
    end

    axi_skid_2 #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH)
    ) u_skid (
        .clk           (clk),
        .reset_n       (reset_n),
        .push          (push_c),
        .push_data     (din_data),
        .push_user     (beat_user_c),
        .push_last     (is_last_c),
        .pop           (pop_c),
        .tail_last_set (overflow_c),
        .out_valid     (head_valid),
        .out_data      (head_data),
        .out_user      (head_user),
        .out_last      (head_last),
        .full_c        (full_c)
    );

    assign m_axis.tvalid = head_valid;
    assign m_axis.tdata  = head_data;
    assign m_axis.tuser  = head_user;
    assign m_axis.tlast  = head_last;

`ifdef AXI_FRAME_WRITER_STATS_EN
    // Saturating frame counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (drop_inc_c && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + LEN_WIDTH'(1);
            end
            if (trunc_inc_c && (trunc_cnt != '1)) begin
                trunc_cnt <= trunc_cnt + LEN_WIDTH'(1);
            end
        end
    end
`else
    logic unused_stats_c;
    assign unused_stats_c = drop_inc_c ^ trunc_inc_c;
    assign drop_cnt       = '0;
    assign trunc_cnt      = '0;
`endif

endmodule

// File: tb/tb_axi_frame_writer.sv
// Scoreboard bench for axi_frame_writer: expected beats queued at stimulus time,
// compared as the DUT hands them off.
module tb_axi_frame_writer;
    import axi_stream_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned UW = 8;
    localparam int unsigned LW = 16;
`ifdef AXI_FRAME_WRITER_STATS_EN
    localparam int unsigned STATS = 1;
`else
    localparam int unsigned STATS = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic [LW-1:0] frame_len = '0;
    logic          almost_full = 1'b0;
    logic          tready = 1'b0;
    logic [LW-1:0] drop_cnt, trunc_cnt;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    axi_frame_writer_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_axis ();
    assign m_axis.tready = tready;

    axi_frame_writer #(
        .DATA_WIDTH  (DW),
        .TUSER_WIDTH (UW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din_valid   (din_valid),
        .din_data    (din_data),
        .frame_len   (frame_len),
        .almost_full (almost_full),
        .m_axis      (m_axis),
        .drop_cnt    (drop_cnt),
        .trunc_cnt   (trunc_cnt)
    );

    // Scoreboard: every handshake must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        beat_t got;
        beat_t exp;
        if (reset_n && m_axis.tvalid && tready) begin
            got = beat_t'{data: m_axis.tdata, user: m_axis.tuser, last: m_axis.tlast};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got data=%h user=%h last=%b, required no beat",
                         got.data, got.user, got.last);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL beat: got data=%h user=%h last=%b, required data=%h user=%h last=%b",
                             got.data, got.user, got.last, exp.data, exp.user, exp.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        din_valid = 1'b1;
        din_data  = d;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
        exp_q.push_back(beat_t'{data: d, user: u, last: l});
    endtask

    task automatic apply_reset();
        din_valid   = 1'b0;
        almost_full = 1'b0;
        tready      = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        exp_q.delete();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors += 6;
        if (m_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b, required 0", m_axis.tvalid); end
        if (m_axis.tdata !== '0)    begin miscompares++; $display("FAIL reset_tdata: got %h, required 0", m_axis.tdata); end
        if (m_axis.tlast !== 1'b0)  begin miscompares++; $display("FAIL reset_tlast: got %b, required 0", m_axis.tlast); end
        if (m_axis.tuser !== '0)    begin miscompares++; $display("FAIL reset_tuser: got %h, required 0", m_axis.tuser); end
        if (drop_cnt !== '0)        begin miscompares++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
        if (trunc_cnt !== '0)       begin miscompares++; $display("FAIL reset_trunc_cnt: got %0d, required 0", trunc_cnt); end
    endtask

    task automatic test_pass();
        apply_reset();
        frame_len = LW'(4);
        tready    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_beat(DW'(32'h100 + i), UW'(i / 4), (i % 4) == 3);
        end
        send(DW'(32'h100));
        vectors += 2;
        if (m_axis.tvalid !== 1'b1) begin miscompares++; $display("FAIL pass_latency_tvalid: got %b, required 1", m_axis.tvalid); end
        if (m_axis.tdata !== DW'(32'h100)) begin miscompares++; $display("FAIL pass_latency_tdata: got %h, required 100", m_axis.tdata); end
        for (int i = 1; i < 8; i++) begin
            send(DW'(32'h100 + i));
        end
        wait_drain("pass");
    endtask

    task automatic test_drop();
        apply_reset();
        tready      = 1'b1;
        frame_len   = LW'(3);
        almost_full = 1'b1;
        send(DW'(32'h200));
        almost_full = 1'b0;
        send(DW'(32'h201));
        send(DW'(32'h202));
        for (int i = 0; i < 3; i++) begin
            expect_beat(DW'(32'h210 + i), UW'(1), i == 2);
        end
        send(DW'(32'h210));
        almost_full = 1'b1;
        send(DW'(32'h211));
        send(DW'(32'h212));
        almost_full = 1'b0;
        wait_drain("drop");
        vectors += 2;
        if (drop_cnt !== LW'(STATS)) begin miscompares++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, STATS); end
        if (trunc_cnt !== '0)        begin miscompares++; $display("FAIL drop_trunc_cnt: got %0d, required 0", trunc_cnt); end
    endtask

    task automatic test_trunc();
        apply_reset();
        tready    = 1'b0;
        frame_len = LW'(8);
        expect_beat(DW'(32'h300), UW'(0), 1'b0);
        expect_beat(DW'(32'h301), UW'(0), 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(DW'(32'h300 + i));
        end
        tick();
        vectors += 5;
        if (m_axis.tvalid !== 1'b1)        begin miscompares++; $display("FAIL trunc_head_valid: got %b, required 1", m_axis.tvalid); end
        if (m_axis.tdata !== DW'(32'h300)) begin miscompares++; $display("FAIL trunc_head_data: got %h, required 300", m_axis.tdata); end
        if (m_axis.tlast !== 1'b0)         begin miscompares++; $display("FAIL trunc_head_last: got %b, required 0", m_axis.tlast); end
        if (trunc_cnt !== LW'(STATS))      begin miscompares++; $display("FAIL trunc_cnt: got %0d, required %0d", trunc_cnt, STATS); end
        if (drop_cnt !== '0)               begin miscompares++; $display("FAIL trunc_drop_cnt: got %0d, required 0", drop_cnt); end
        tready = 1'b1;
        wait_drain("trunc");
        frame_len = LW'(2);
        expect_beat(DW'(32'h310), UW'(1), 1'b0);
        expect_beat(DW'(32'h311), UW'(1), 1'b1);
        send(DW'(32'h310));
        send(DW'(32'h311));
        wait_drain("trunc_next");
    endtask

    task automatic test_no_overflow();
        apply_reset();
        tready    = 1'b0;
        frame_len = LW'(4);
        for (int i = 0; i < 4; i++) begin
            expect_beat(DW'(32'h400 + i), UW'(0), i == 3);
        end
        send(DW'(32'h400));
        send(DW'(32'h401));
        tready = 1'b1;
        send(DW'(32'h402));
        send(DW'(32'h403));
        wait_drain("no_ovf");
        vectors++;
        if (trunc_cnt !== '0) begin miscompares++; $display("FAIL no_ovf_trunc_cnt: got %0d, required 0", trunc_cnt); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tready    = 1'b0;
        frame_len = LW'(4);
        send(DW'(32'h500));
        send(DW'(32'h501));
        #2;
        reset_n = 1'b0;
        #1;
        vectors += 4;
        if (m_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_tvalid: got %b, required 0", m_axis.tvalid); end
        if (m_axis.tdata !== '0)    begin miscompares++; $display("FAIL mid_reset_tdata: got %h, required 0", m_axis.tdata); end
        if (m_axis.tlast !== 1'b0)  begin miscompares++; $display("FAIL mid_reset_tlast: got %b, required 0", m_axis.tlast); end
        if (m_axis.tuser !== '0)    begin miscompares++; $display("FAIL mid_reset_tuser: got %h, required 0", m_axis.tuser); end
        tick();
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        tready    = 1'b1;
        frame_len = LW'(1);
        expect_beat(DW'(32'h510), UW'(0), 1'b1);
        send(DW'(32'h510));
        wait_drain("mid_reset");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tready    = 1'b1;
        frame_len = '0;
        for (int i = 0; i < 260; i++) begin
            expect_beat(DW'(32'h600 + i), UW'(i), 1'b1);
            send(DW'(32'h600 + i));
        end
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_pass();
        test_drop();
        test_trunc();
        test_no_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required completion within time limit");
        $fatal(1);
    end

endmodule

// File: doc/axi_frame_writer.md
AXI_FRAME_WRITER -- requirements
Module: axi_frame_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning sample/tdata width.
REQ-002 SHALL have parameter TUSER_WIDTH, default 8, meaning frame sequence number width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning frame_len and counter width.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port din_valid, input, 1 bit; sample strobe, no backpressure.
REQ-007 SHALL have port din_data, input, DATA_WIDTH; sample value.
REQ-008 SHALL have port frame_len, input, LEN_WIDTH; beats per frame, sampled at frame start.
REQ-009 SHALL have port almost_full, input, 1 bit; downstream FIFO level flag.
REQ-010 SHALL have ports m_axis_tvalid/tdata/tlast/tuser (output, 1/DATA_WIDTH/1/TUSER_WIDTH) and m_axis_tready (input, 1); AXI-Stream master.
REQ-011 SHALL have ports drop_cnt and trunc_cnt, output, LEN_WIDTH each; saturating frame counters.

Function
REQ-012 SHALL run an FSM with states IDLE, PASS, DROP; frame start = din_valid in IDLE.
REQ-013 At frame start SHALL latch len = max(frame_len,1), clear beat count, and go to PASS if almost_full==0, else DROP.
REQ-014 Every frame start (passed or dropped) SHALL increment seq (TUSER_WIDTH, wraps); all beats of a frame carry that frame's pre-increment seq on m_axis_tuser.
REQ-015 In PASS, each din_valid SHALL push {din_data, seq, last} into a 2-entry output buffer, last=1 on beat len; after beat len return to IDLE.
REQ-016 In DROP, samples SHALL be discarded; after beat len drop_cnt SHALL increment (saturating at all-ones) and FSM returns to IDLE.
REQ-017 Latency din_valid to m_axis_tvalid SHALL be 1 cycle when buffer empty.
REQ-018 A beat SHALL leave the buffer only on m_axis_tvalid && m_axis_tready; presented head beat SHALL be stable while tvalid=1 and tready=0.
REQ-019 Overflow = PASS push while buffer holds 2 entries and no pop in the same cycle; push+pop same cycle SHALL never overflow.
REQ-020 On overflow the sample SHALL be lost, tail entry (not yet presented) SHALL get tlast=1, trunc_cnt SHALL increment (saturating), FSM SHALL go DROP for the remaining beats (IDLE if overflowing beat was beat len); drop_cnt not incremented for it.
REQ-021 If tail is absent (buffer 2 entries means tail exists) tlast forcing SHALL never modify the presented head.
REQ-022 len=1 frames SHALL emit single beats with tlast=1; back-to-back frames with zero gap SHALL be supported.

Reset
REQ-023 reset_n low SHALL asynchronously force FSM IDLE, buffer empty, seq=0, counters=0, m_axis_tvalid=0, tlast=0, tdata=0, tuser=0.
REQ-024 Reset mid-frame SHALL abort the frame with no tlast emitted; first frame after release uses seq 0.

Configuration
REQ-025 Macro AXI_FRAME_WRITER_STATS_EN defined SHALL compile in drop_cnt/trunc_cnt logic; undefined, both ports SHALL be constant 0 and all other behaviour identical.

Structure
REQ-026 FSM state encoding and default widths SHALL live in shared package axi_stream_pkg.
REQ-027 The 2-entry output buffer SHALL be sub-module axi_skid_2 with push/pop/tail-tlast-set inputs.

Verification
REQ-028 frame_len=4, tready=1, almost_full=0, 8 consecutive samples -> two frames, tlast on beats 4 and 8, tuser 0 then 1, latency 1.
REQ-029 almost_full=1 at frame start, frame_len=3 -> 3 samples discarded, drop_cnt=1, next passed frame tuser=1.
REQ-030 frame_len=8, tready=0 from beat 1, 3 samples -> beats 1,2 held, beat 2 tlast=1, trunc_cnt=1, remaining 5 dropped, next frame passes.
REQ-031 Buffer full, tready=1 same cycle as push -> no overflow, trunc_cnt stays 0.
REQ-032 reset_n low mid-frame (beat 2 of 4) -> all outputs 0 immediately; restart frame tuser=0.
REQ-033 Build without AXI_FRAME_WRITER_STATS_EN, repeat REQ-029/030 -> counters read 0, stream identical.
